// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan capture: glyph table, codes,
// anode patterns and frame FSM state encoding.
package seg_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned AN_W   = 4;
   localparam int unsigned CODE_W = 5;

   // Active-low glyphs, bit 6 = g .. bit 0 = a; index = hex value
   localparam logic [15:0][SEG_W-1:0] GLYPH_HEX = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
   localparam logic [SEG_W-1:0] GLYPH_H     = 7'b0001001;
   localparam logic [SEG_W-1:0] GLYPH_N     = 7'b1001000;
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

   localparam logic [CODE_W-1:0] CODE_H     = 5'h10;
   localparam logic [CODE_W-1:0] CODE_N     = 5'h11;
   localparam logic [CODE_W-1:0] CODE_BLANK = 5'h12;
   localparam logic [CODE_W-1:0] CODE_BAD   = 5'h1F;

   localparam logic [AN_W-1:0] AN_L    = 4'b0111;
   localparam logic [AN_W-1:0] AN_ML   = 4'b1011;
   localparam logic [AN_W-1:0] AN_MR   = 4'b1101;
   localparam logic [AN_W-1:0] AN_R    = 4'b1110;
   localparam logic [AN_W-1:0] AN_NONE = 4'b1111;

   typedef enum logic [1:0] {
      ST_WAIT_L = 2'd0,
      ST_EXP_ML = 2'd1,
      ST_EXP_MR = 2'd2,
      ST_EXP_R  = 2'd3
   } state_e;

   // Shadow slot (3=left .. 0=right) addressed by a one-hot-low anode value
   function automatic logic [1:0] an_slot(input logic [AN_W-1:0] an);
      logic [1:0] slot;
      slot = 2'd0;
      unique case (an)
         AN_L:    slot = 2'd3;
         AN_ML:   slot = 2'd2;
         AN_MR:   slot = 2'd1;
         default: slot = 2'd0;
      endcase
      return slot;
   endfunction

   // Anode the FSM waits for next in each state
   function automatic logic [AN_W-1:0] an_expected(input state_e st);
      logic [AN_W-1:0] an;
      unique case (st)
         ST_WAIT_L: an = AN_L;
         ST_EXP_ML: an = AN_ML;
         ST_EXP_MR: an = AN_MR;
         default:   an = AN_R;
      endcase
      return an;
   endfunction

   // Anode of the slot most recently written within the current frame
   function automatic logic [AN_W-1:0] an_last(input state_e st);
      logic [AN_W-1:0] an;
      unique case (st)
         ST_WAIT_L: an = AN_NONE;
         ST_EXP_ML: an = AN_L;
         ST_EXP_MR: an = AN_ML;
         default:   an = AN_MR;
      endcase
      return an;
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment pattern to 5-bit character code decoder.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [4:0] code_c
);

   // 0010000 is reported as 9; G shares the same pattern
   always_comb begin
      code_c = CODE_BAD;
      for (int i = 0; i < 16; i++) begin
         if (glyph == GLYPH_HEX[i]) code_c = 5'(i);
      end
      if (glyph == GLYPH_H)     code_c = CODE_H;
      if (glyph == GLYPH_N)     code_c = CODE_N;
      if (glyph == GLYPH_BLANK) code_c = CODE_BLANK;
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: filters samples, tracks scan
// order and publishes one decoded four-digit frame at a time.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        segclk,
   input  logic        clr_n,
   input  logic        sample_en,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [27:0] raw,
   output logic [19:0] codes,
   output logic        frame_valid,
   output logic        an_err,
   output logic        seq_err,
   output logic        stale
);

   localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT);
   localparam int unsigned CAND_W = AN_W + SEG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);
   localparam logic [CODE_W-1:0] CODE_RST = CODE_BLANK;

   logic [CAND_W-1:0]     cand_q, cand_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   state_e                state_q, state_d;
   logic [3:0][SEG_W-1:0] shadow_q, shadow_d;
   logic [27:0]           raw_q, raw_d;
   logic [19:0]           codes_q, codes_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  an_err_q, an_err_d;
   logic                  seq_err_q, seq_err_d;
   logic                  stale_q, stale_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;

   logic                  commit;
   logic                  publish;
   logic [3:0][CODE_W-1:0] code_w;

   // Stability filter, commit classification and frame sequencing
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      shadow_d  = shadow_q;
      an_err_d  = 1'b0;
      seq_err_d = 1'b0;
      commit    = 1'b0;
      publish   = 1'b0;

      if (sample_en) begin
         if ({an_in, seg_in} != cand_q) begin
            cand_d = {an_in, seg_in};
            cnt_d  = CNT_W'(1);
            commit = (STABLE_CNT == 1);
         end else if (cnt_q < CNT_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
            commit = (cnt_d == CNT_MAX);
         end
      end

      if (commit && (an_in != AN_NONE)) begin
         if (an_in == AN_L) begin
            shadow_d[3] = seg_in;
            state_d     = ST_EXP_ML;
         end else if ($countones(~an_in) != 1) begin
            an_err_d = 1'b1;
            state_d  = ST_WAIT_L;
         end else if (an_in == an_expected(state_q)) begin
            shadow_d[an_slot(an_in)] = seg_in;
            unique case (state_q)
               ST_EXP_ML: state_d = ST_EXP_MR;
               ST_EXP_MR: state_d = ST_EXP_R;
               default: begin
                  state_d = ST_WAIT_L;
                  publish = 1'b1;
               end
            endcase
         end else if (an_in == an_last(state_q)) begin
            shadow_d[an_slot(an_in)] = seg_in;
         end else begin
            seq_err_d = 1'b1;
            state_d   = ST_WAIT_L;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dec
      seg_glyph_decode u_dec (
         .glyph  (shadow_d[g]),
         .code_c (code_w[g])
      );
   end

   // Frame publication and staleness timer; a completed frame beats expiry
   always_comb begin
      raw_d         = raw_q;
      codes_d       = codes_q;
      tmo_d         = tmo_q;
      stale_d       = stale_q;
      frame_valid_d = publish;
      if (publish) begin
         raw_d   = shadow_d;
         codes_d = code_w;
         tmo_d   = '0;
         stale_d = 1'b0;
      end else begin
         if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
         if (tmo_d == TMO_MAX) stale_d = 1'b1;
      end
   end

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         cand_q        <= {AN_NONE, GLYPH_BLANK};
         cnt_q         <= CNT_MAX;
         state_q       <= ST_WAIT_L;
         shadow_q      <= {4{GLYPH_BLANK}};
         raw_q         <= {4{GLYPH_BLANK}};
         codes_q       <= {4{CODE_RST}};
         frame_valid_q <= 1'b0;
         an_err_q      <= 1'b0;
         seq_err_q     <= 1'b0;
         stale_q       <= 1'b1;
         tmo_q         <= '0;
      end else begin
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         raw_q         <= raw_d;
         codes_q       <= codes_d;
         frame_valid_q <= frame_valid_d;
         an_err_q      <= an_err_d;
         seq_err_q     <= seq_err_d;
         stale_q       <= stale_d;
         tmo_q         <= tmo_d;
      end
   end

   assign raw         = raw_q;
   assign codes       = codes_q;
   assign frame_valid = frame_valid_q;
   assign an_err      = an_err_q;
   assign seq_err     = seq_err_q;
   assign stale       = stale_q;

endmodule
